// File: rtl/fetch_buffer_if.sv
// Fetch-buffer handshake bundle: the fetch-side push channel, the flush strobe and the decode-side pop channel.
// master: the producer/consumer environment (PC/IMEM stage plus decode).
// slave: the buffer itself.
//
// Fetch side : in_valid/in_ready handshake carrying in_pc, in_pcplus4 and in_instr.
// Control    : flush, a redirect that discards every buffered entry.
// Decode side: out_valid/out_ready handshake carrying out_pc, out_pcplus4 and out_instr,
//              plus count, the current occupancy.
interface fetch_buffer_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_pc;
   logic [WIDTH-1:0] in_pcplus4;
   logic [WIDTH-1:0] in_instr;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_pc;
   logic [WIDTH-1:0] out_pcplus4;
   logic [WIDTH-1:0] out_instr;
   logic [CW-1:0]    count;

   modport master (
      output in_valid, in_pc, in_pcplus4, in_instr, flush, out_ready,
      input  in_ready, out_valid, out_pc, out_pcplus4, out_instr, count
   );

   modport slave (
      input  in_valid, in_pc, in_pcplus4, in_instr, flush, out_ready,
      output in_ready, out_valid, out_pc, out_pcplus4, out_instr, count
   );
endinterface

// File: rtl/fetch_buffer.sv
// Fetch buffer: a circular FIFO of {pc, pc+4, instr} between the fetch stage and decode.
// Latency: an entry pushed on edge N appears at the head in cycle N+1; there is no bypass.
// Backpressure: in_ready drops when the buffer is full or in reset. Pops only occur while out_valid is high.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-low reset
//   bus  - fetch_buffer_if.slave (the push channel in_*, flush, the pop channel out_*, and count)
module fetch_buffer #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   fetch_buffer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [WIDTH-1:0] NOP_INSTR  = WIDTH'(32'h0000_0013);
   localparam logic [CW-1:0]    FULL_COUNT = CW'(DEPTH);

   typedef struct packed {
      logic [WIDTH-1:0] pc;
      logic [WIDTH-1:0] pcplus4;
      logic [WIDTH-1:0] instr;
   } entry_t;

   entry_t        r_mem [DEPTH];
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;

   logic          w_in_ready;
   logic          w_out_valid;
   logic          w_push;
   logic          w_pop;
   entry_t        w_head;

   // in_ready is gated with rst so that upstream holds its PC while reset is asserted.
   // A full buffer refuses a push even if a pop happens in the same cycle.
   // This keeps in_ready independent of out_ready.
   assign w_in_ready  = rst && (r_count < FULL_COUNT);
   assign w_out_valid = (r_count != '0);
   assign w_push      = bus.in_valid && w_in_ready;
   assign w_pop       = w_out_valid && bus.out_ready;

   assign w_head = r_mem[r_rd_ptr];

   // Pointers and occupancy. Reset outranks flush, and flush outranks push/pop.
   // The pointers are log2(DEPTH) bits wide, so they wrap naturally when DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (bus.flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage has no reset. A fetch that arrives together with a flush is dropped.
   // The write is suppressed so that a stale entry cannot resurface.
   always_ff @(posedge clk) begin
      if (w_push && !bus.flush) begin
         r_mem[r_wr_ptr] <= '{pc: bus.in_pc, pcplus4: bus.in_pcplus4, instr: bus.in_instr};
      end
   end

   // When the buffer is empty, decode sees a NOP with zero PCs rather than stale storage.
   assign bus.in_ready    = w_in_ready;
   assign bus.out_valid   = w_out_valid;
   assign bus.out_pc      = w_out_valid ? w_head.pc      : '0;
   assign bus.out_pcplus4 = w_out_valid ? w_head.pcplus4 : '0;
   assign bus.out_instr   = w_out_valid ? w_head.instr   : NOP_INSTR;
   assign bus.count       = r_count;

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer (WIDTH=32, DEPTH=4).
// The cases are: reset, fill and reject, full with a pop, drain, wrap-around, push and pop together, flush, and reset in mid-operation.
// The inputs are driven 1-2 time units after the rising edge, and the outputs are sampled in the same window.
module tb_fetch_buffer;
   localparam int WIDTH = 32;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   fetch_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   fetch_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return pc ^ 32'hDEAD_0000;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic ordy, input logic fl);
      bus.in_valid   = v;
      bus.in_pc      = pc;
      bus.in_pcplus4 = pc + 32'd4;
      bus.in_instr   = instr_of(pc);
      bus.out_ready  = ordy;
      bus.flush      = fl;
      #1;
   endtask

   task automatic check_head(input string tag, input logic [31:0] pc);
      check({tag, ".pc"},    bus.out_pc,      pc);
      check({tag, ".pc4"},   bus.out_pcplus4, pc + 32'd4);
      check({tag, ".instr"}, bus.out_instr,   instr_of(pc));
   endtask

   initial begin
      int got;

      // Reset held for 2 cycles with in_valid asserted.
      rst = 1'b0;
      drive(1'b1, 32'h100, 1'b0, 1'b0);
      step();
      step();
      check("rst.count",     32'(bus.count), 32'd0);
      check("rst.out_valid", 32'(bus.out_valid), 32'd0);
      check("rst.out_instr", bus.out_instr, 32'h0000_0013);
      check("rst.out_pc",    bus.out_pc, 32'd0);
      check("rst.in_ready",  32'(bus.in_ready), 32'd0);
      rst = 1'b1;
      #1;
      check("rst.rel_in_ready", 32'(bus.in_ready), 32'd1);

      // Fill to 4 entries. There is no bypass, so the head is still empty while the first push is pending.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'(4 * i), 1'b0, 1'b0);
         if (i == 0) check("fill.no_bypass", 32'(bus.out_valid), 32'd0);
         step();
      end
      check("fill.count",    32'(bus.count), 32'd4);
      check("fill.in_ready", 32'(bus.in_ready), 32'd0);

      // A fifth push is rejected and the head is unchanged.
      drive(1'b1, 32'h10, 1'b0, 1'b0);
      step();
      check("reject.count", 32'(bus.count), 32'd4);
      check_head("reject.head", 32'h0);

      // While full, a pop together with a push request: only the pop happens.
      drive(1'b1, 32'h10, 1'b1, 1'b0);
      step();
      check("fullpop.count", 32'(bus.count), 32'd3);
      check_head("fullpop.head", 32'h4);

      // Drain the rest in order.
      for (int k = 1; k < 4; k++) begin
         drive(1'b0, 32'h0, 1'b1, 1'b0);
         check($sformatf("drain.pc%0d", k), bus.out_pc, 32'(4 * k));
         step();
      end
      check("drain.count",     32'(bus.count), 32'd0);
      check("drain.out_valid", 32'(bus.out_valid), 32'd0);
      check("drain.nop",       bus.out_instr, 32'h0000_0013);
      check("drain.pc4_zero",  bus.out_pcplus4, 32'd0);

      // A pop while empty is a no-op.
      step();
      check("empty_pop.count", 32'(bus.count), 32'd0);

      // Wrap-around: push 6 entries while popping continuously.
      got = 0;
      for (int c = 0; c < 10; c++) begin
         if (c < 6) drive(1'b1, 32'(4 * c), 1'b1, 1'b0);
         else       drive(1'b0, 32'h0, 1'b1, 1'b0);
         if (bus.out_valid) begin
            check($sformatf("wrap.pop%0d", got), bus.out_pc, 32'(4 * got));
            got++;
         end
         step();
      end
      check("wrap.total", 32'(got), 32'd6);
      check("wrap.count", 32'(bus.count), 32'd0);

      // Push and pop together, starting with count=2.
      drive(1'b1, 32'h20, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'h24, 1'b0, 1'b0);
      step();
      check("simul.pre_count", 32'(bus.count), 32'd2);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'(32'h28 + 4 * i), 1'b1, 1'b0);
         check($sformatf("simul.head%0d", i), bus.out_pc, 32'(32'h20 + 4 * i));
         step();
         check($sformatf("simul.count%0d", i), 32'(bus.count), 32'd2);
      end
      drive(1'b1, 32'h34, 1'b0, 1'b0);
      step();
      check("simul.count3", 32'(bus.count), 32'd3);
      check_head("simul.head_after", 32'h2C);

      // Flush with a push (pc 0x40) and a pop in the same cycle.
      drive(1'b1, 32'h40, 1'b1, 1'b1);
      step();
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      check("flush.count",     32'(bus.count), 32'd0);
      check("flush.out_valid", 32'(bus.out_valid), 32'd0);
      check("flush.in_ready",  32'(bus.in_ready), 32'd1);
      check("flush.out_pc",    bus.out_pc, 32'd0);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 32'h0, 1'b1, 1'b0);
         check($sformatf("flush.no40_%0d", i), 32'(bus.out_valid), 32'd0);
         step();
      end
      drive(1'b1, 32'h50, 1'b0, 1'b0);
      step();
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      check_head("postflush.head", 32'h50);
      check("postflush.count", 32'(bus.count), 32'd1);

      // Reset in mid-operation with count=3 and a concurrent push and pop.
      drive(1'b1, 32'h54, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'h58, 1'b0, 1'b0);
      step();
      check("midrst.pre_count", 32'(bus.count), 32'd3);
      rst = 1'b0;
      drive(1'b1, 32'h5C, 1'b1, 1'b0);
      check("midrst.in_ready_low", 32'(bus.in_ready), 32'd0);
      step();
      check("midrst.count",     32'(bus.count), 32'd0);
      check("midrst.out_valid", 32'(bus.out_valid), 32'd0);
      check("midrst.nop",       bus.out_instr, 32'h0000_0013);
      rst = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      check("midrst.rel_in_ready", 32'(bus.in_ready), 32'd1);
      step();
      check("midrst.still_empty", 32'(bus.count), 32'd0);
      drive(1'b1, 32'h70, 1'b0, 1'b0);
      step();
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      check_head("midrst.new_head", 32'h70);
      check("midrst.new_count", 32'(bus.count), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data width of instruction and address fields.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of buffer entries; legal values are powers of two, minimum 2.
REQ-003 The block SHALL have port clk  input  1  single rising-edge clock.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-low (0 = reset).
REQ-005 The block SHALL have port in_valid  input  1  fetch slot valid from the program-counter/instruction-memory stage.
REQ-006 The block SHALL have port in_ready  output  1  buffer can accept a fetch this cycle; used upstream to hold PC.
REQ-007 The block SHALL have port in_pc  input  WIDTH  PC of the fetched instruction.
REQ-008 The block SHALL have port in_pcplus4  input  WIDTH  PC+4 of the fetched instruction.
REQ-009 The block SHALL have port in_instr  input  WIDTH  instruction word read at in_pc.
REQ-010 The block SHALL have port flush  input  1  redirect (PCSrc != 00) discards all buffered entries.
REQ-011 The block SHALL have port out_valid  output  1  head entry valid for decode.
REQ-012 The block SHALL have port out_ready  input  1  decode accepts the head entry.
REQ-013 The block SHALL have port out_pc  output  WIDTH  PC of the head entry.
REQ-014 The block SHALL have port out_pcplus4  output  WIDTH  PC+4 of the head entry.
REQ-015 The block SHALL have port out_instr  output  WIDTH  instruction of the head entry.
REQ-016 The block SHALL have port count  output  log2(DEPTH)+1  number of occupied entries.

Function
REQ-017 The block SHALL be a circular FIFO with read pointer, write pointer (log2(DEPTH) bits, wrapping DEPTH-1 -> 0) and an occupancy counter.
REQ-018 The block SHALL perform a push on a rising edge when in_valid=1 and in_ready=1, storing {in_pc, in_pcplus4, in_instr} at the write pointer.
REQ-019 The block SHALL perform a pop on a rising edge when out_valid=1 and out_ready=1, advancing the read pointer.
REQ-020 The block SHALL drive in_ready = 1 exactly when count < DEPTH and rst = 1; a full buffer SHALL NOT accept a push even when a pop occurs in the same cycle.
REQ-021 The block SHALL drive out_valid = 1 exactly when count > 0; there is no bypass, so an entry pushed in cycle N is first visible in cycle N+1.
REQ-022 The block SHALL, when out_valid=0, drive out_instr = 32'h00000013 (NOP), out_pc = 0 and out_pcplus4 = 0; otherwise these SHALL show the head entry combinationally from storage.
REQ-023 The block SHALL leave count unchanged on a simultaneous push and pop, increment it on push only, and decrement it on pop only.
REQ-024 The block SHALL, on a rising edge with flush=1, set both pointers and count to 0; the flush SHALL override any same-cycle push or pop, so the incoming fetch is dropped.
REQ-025 The block SHALL make count, out_valid and in_ready reflect the flush from the cycle following the flush edge: count=0, out_valid=0, in_ready=1.
REQ-026 The block SHALL never let count exceed DEPTH or fall below 0; a pop when empty and a push when full SHALL be no-ops.

Reset
REQ-027 The block SHALL, on a rising edge with rst=0, clear the pointers and count to 0; storage contents need not be cleared.
REQ-028 The block SHALL drive in_ready=0 while rst=0, and drive out_valid=0 together with the REQ-022 empty values from the first edge after reset is asserted.
REQ-029 The block SHALL give reset priority over flush, push and pop, and SHALL apply it mid-operation with no partial state retained.

Verification
REQ-030 Reset: hold rst=0 for 2 cycles with in_valid=1 -> count=0, out_valid=0, out_instr=0x00000013, in_ready=0; after rst=1, in_ready=1.
REQ-031 Fill: push PCs 0x0, 0x4, 0x8, 0xC with out_ready=0 -> count=4, in_ready=0; a fifth push (pc 0x10) is rejected and the head stays pc=0x0, pcplus4=0x4.
REQ-032 Wrap-around: with DEPTH=4, push 6 entries while popping continuously -> pops return PCs in order 0x0..0x14, and the pointers wrap without loss.
REQ-033 Simultaneous push/pop: with count=2, in_valid=1 and out_ready=1 for 3 cycles -> count stays 2 and the output order is preserved.
REQ-034 Flush: with count=3, assert flush together with in_valid=1 (pc 0x40) -> next cycle count=0, out_valid=0; pc 0x40 is never output.
REQ-035 Reset mid-operation: with count=3, pull rst=0 for one cycle concurrently with a push and a pop -> count=0, out_valid=0 on the following cycle.
